// File: rtl/bmp_ram_arbiter.sv
// bmp_ram_arbiter: two-requester (writer/reader) arbiter onto a single-port RAM
// with round-robin tie break, bounded bursts and address range checking.
`default_nettype none

module bmp_ram_arbiter #(
  parameter int ADDR_WIDTH     = 20,
  parameter int BYTE_WIDTH     = 8,
  parameter int BMP_TOTAL_SIZE = 786486,
  parameter int MAX_BURST      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BYTE_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [BYTE_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic                  RAM_ren,
  output logic                  RAM_wen,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic [BYTE_WIDTH-1:0] RAM_in,
  input  logic [BYTE_WIDTH-1:0] RAM_out
);

  localparam int                  CW         = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_WIDTH:0] LIMIT      = (ADDR_WIDTH + 1)'(BMP_TOTAL_SIZE);
  localparam logic [CW-1:0]       BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rr_rd;   // 1: reader owned the port last, so the writer wins a tie
  logic          wr_oor;
  logic          rd_oor;

  assign wr_oor = ({1'b0, wr_addr} >= LIMIT);
  assign rd_oor = ({1'b0, rd_addr} >= LIMIT);

  // Grants and strobes are combinational so a beat completes in the cycle it is offered.
  assign wr_gnt  = (state == WR) && wr_req;
  assign rd_gnt  = (state == RD) && rd_req;
  assign RAM_wen = wr_gnt && !wr_oor;
  assign RAM_ren = rd_gnt && !rd_oor;

  always_comb begin
    RAM_addr = '0;
    RAM_in   = '0;
    if (RAM_wen) begin
      RAM_addr = wr_addr;
      RAM_in   = wr_data;
    end else if (RAM_ren) begin
      RAM_addr = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_rd    <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;
      addr_err <= (wr_gnt && wr_oor) || (rd_gnt && rd_oor);
      if (rd_gnt) rd_data <= rd_oor ? '0 : RAM_out;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (wr_req && (!rd_req || rr_rd)) state <= WR;
          else if (rd_req)                  state <= RD;
        end
        WR: begin
          if (!wr_req) begin
            state <= rd_req ? RD : IDLE;
            rr_rd <= 1'b0;
            cnt   <= '0;
          end else if (cnt == BURST_LAST) begin
            // Burst limit only forces a handover when the reader is waiting.
            cnt <= '0;
            if (rd_req) begin
              state <= RD;
              rr_rd <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD: begin
          if (!rd_req) begin
            state <= wr_req ? WR : IDLE;
            rr_rd <= 1'b1;
            cnt   <= '0;
          end else if (cnt == BURST_LAST) begin
            cnt <= '0;
            if (wr_req) begin
              state <= WR;
              rr_rd <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/bmp_ram_arbiter.md
BMP_RAM_ARBITER -- requirements
Module: bmp_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, RAM address width.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, RAM data width.
REQ-003 SHALL have parameter BMP_TOTAL_SIZE, default 786486, number of valid RAM locations (addresses 0..BMP_TOTAL_SIZE-1).
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum consecutive beats one requester may hold the port while the other is waiting.
REQ-005 SHALL have ports, one clock, asynchronous active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  1  writer requests a write beat
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  BYTE_WIDTH  write data
- wr_gnt  out  1  write beat accepted this cycle
- rd_req  in  1  reader requests a read beat
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read beat accepted this cycle
- rd_data  out  BYTE_WIDTH  registered read data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- addr_err  out  1  one-cycle pulse: previous accepted beat was out of range
- RAM_ren  out  1  RAM read enable
- RAM_wen  out  1  RAM write enable
- RAM_addr  out  ADDR_WIDTH  RAM address
- RAM_in  out  BYTE_WIDTH  RAM write data
- RAM_out  in  BYTE_WIDTH  RAM read data (combinational, valid same cycle as RAM_ren)

Function
REQ-006 SHALL implement three states: IDLE, WR (port owned by writer), RD (port owned by reader); state register, burst counter, rr pointer are the only ownership state.
REQ-007 SHALL in IDLE drive RAM_ren=0, RAM_wen=0, RAM_addr=0, RAM_in=0, wr_gnt=0, rd_gnt=0.
REQ-008 SHALL from IDLE: only wr_req -> WR; only rd_req -> RD; both -> requester not equal to rr pointer; neither -> IDLE (one bubble cycle between IDLE and first beat).
REQ-009 SHALL in WR with wr_req=1: wr_gnt=1, RAM_wen=1, RAM_ren=0, RAM_addr=wr_addr, RAM_in=wr_data, same cycle (combinational from inputs and state).
REQ-010 SHALL in RD with rd_req=1: rd_gnt=1, RAM_ren=1, RAM_wen=0, RAM_addr=rd_addr, RAM_in=0; rd_data<=RAM_out and rd_valid=1 on the following cycle (latency 1).
REQ-011 SHALL never assert RAM_ren and RAM_wen in the same cycle, never assert wr_gnt and rd_gnt in the same cycle.
REQ-012 SHALL count accepted beats in the owning state; counter clears on every state change.
REQ-013 SHALL leave WR/RD when owner req=0: other req=1 -> other state, else IDLE; rr pointer <= leaving owner.
REQ-014 SHALL leave WR/RD when counter reaches MAX_BURST on an accepted beat and the other req=1: switch to the other state, rr pointer <= leaving owner; if other req=0, stay and clear counter.
REQ-015 SHALL treat an accepted beat with address >= BMP_TOTAL_SIZE as out of range: gnt still 1, RAM_wen/RAM_ren forced 0, RAM_addr=0, addr_err=1 next cycle; out-of-range read gives rd_valid=1 with rd_data=0.
REQ-016 SHALL require requesters to hold addr/data stable while req=1 and gnt=0; dropping req before gnt is legal and consumes nothing.
REQ-017 SHALL keep rd_data at last value when rd_valid=0.

Reset
REQ-018 SHALL on rst_n=0 immediately force state=IDLE, counter=0, rr pointer=RD (writer wins first tie), rd_data=0, rd_valid=0, addr_err=0, and hence all RAM strobes and grants 0.
REQ-019 SHALL abort any beat in progress when reset asserts before the clock edge: no RAM write occurs, no rd_valid issued afterwards.
REQ-020 SHALL after rst_n release behave as from IDLE on the first rising edge.

Verification
REQ-021 Reset: rst_n=0 mid-WR beat with wr_req=1 -> RAM_wen=0, wr_gnt=0 same cycle; RAM location unchanged.
REQ-022 Write then read: write 0xA5 to addr 54, then read addr 54 -> rd_valid=1, rd_data=0xA5 one cycle after rd_gnt.
REQ-023 Tie: wr_req=rd_req=1 from reset -> WR granted first; after MAX_BURST=16 beats -> RD for 16 beats -> WR again; no cycle with both grants.
REQ-024 Early release: writer drops wr_req after 3 beats with rd_req=1 -> RD next cycle, counter restarts at 0.
REQ-025 Range: read addr BMP_TOTAL_SIZE -> rd_gnt=1, RAM_ren=0, next cycle rd_valid=1, rd_data=0, addr_err=1; write addr BMP_TOTAL_SIZE+5 -> RAM_wen=0, addr_err=1.
REQ-026 Solo burst: only wr_req=1 for 40 beats -> stays WR, 40 consecutive wr_gnt, no bubble at counter wrap.
